// File: rtl/layer_x_stream_tx.sv
// Vector buffer that loads LENX words from a stream and sends them toward layer x.
// Optional replay of the stored vector is enabled by defining LAYER_X_STREAM_TX_REPLAY_EN.
module layer_x_stream_tx #(
    parameter int WIDTH = 16,
    parameter int LENX  = 24,
    parameter int ADDRX = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] m_data_out_x,
    output logic                    m_valid_x,
    input  logic                    m_ready_x,
    input  logic                    replay,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [ADDRX-1:0] LAST_IDX = ADDRX'(LENX - 1);

    state_t                  state_reg, state_next;
    logic [ADDRX-1:0]        wcnt_reg, wcnt_next;
    logic [ADDRX-1:0]        rcnt_reg, rcnt_next;
    logic [ADDRX-1:0]        rd_addr;
    logic                    rd_en;
    logic                    done_next;
    logic signed [WIDTH-1:0] data_reg;
    logic                    valid_reg;
    logic                    ready_reg;
    logic                    done_reg;
    logic                    load_fire;
    logic                    send_fire;
    logic                    replay_go;
    logic                    fwd_hit;

    logic signed [WIDTH-1:0] buffer [0:LENX-1];

    assign load_fire = s_valid && ready_reg && (state_reg == LOAD);
    assign send_fire = valid_reg && m_ready_x;

`ifdef LAYER_X_STREAM_TX_REPLAY_EN
    assign replay_go = (state_reg == WAIT) && replay;
`else
    // replay has no effect in this build
    assign replay_go = replay && 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        rcnt_next  = rcnt_reg;
        rd_addr    = rcnt_reg;
        rd_en      = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: state_next = LOAD;
            LOAD: begin
                if (load_fire) begin
                    if (wcnt_reg == LAST_IDX) begin
                        // prefetch word 0 so valid rises the cycle SEND is entered
                        state_next = SEND;
                        wcnt_next  = '0;
                        rcnt_next  = '0;
                        rd_addr    = '0;
                        rd_en      = 1'b1;
                    end else begin
                        wcnt_next = wcnt_reg + ADDRX'(1);
                    end
                end
            end
            SEND: begin
                rd_en = 1'b1;
                if (send_fire) begin
                    if (rcnt_reg == LAST_IDX) begin
                        state_next = WAIT;
                        rcnt_next  = '0;
                        rd_en      = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        rcnt_next = rcnt_reg + ADDRX'(1);
                        rd_addr   = rcnt_reg + ADDRX'(1);
                    end
                end
            end
            WAIT: begin
                if (replay_go) begin
                    state_next = SEND;
                    rcnt_next  = '0;
                    rd_addr    = '0;
                    rd_en      = 1'b1;
                end else begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Read-during-write on the same address (only possible when LENX is 1) takes the new word.
    assign fwd_hit = load_fire && (wcnt_reg == rd_addr);

    always_ff @(posedge clk) begin
        if (load_fire) begin
            buffer[wcnt_reg] <= s_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= LOAD;
            wcnt_reg  <= '0;
            rcnt_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            rcnt_reg  <= rcnt_next;
            valid_reg <= (state_next == SEND);
            ready_reg <= (state_next == LOAD);
            done_reg  <= done_next;
            if (rd_en) begin
                data_reg <= fwd_hit ? s_data_in : buffer[rd_addr];
            end
        end
    end

    assign s_ready      = ready_reg;
    assign m_valid_x    = valid_reg;
    assign m_data_out_x = data_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_layer_x_stream_tx.sv
// Directed bench for layer_x_stream_tx: scoreboard of loaded words checked against sent words.
module tb_layer_x_stream_tx;

    localparam int WIDTH = 16;
    localparam int LENX  = 24;
    localparam int ADDRX = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] s_data_in = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] m_data_out_x;
    logic             m_valid_x;
    logic             m_ready_x = 1'b0;
    logic             replay = 1'b0;
    logic             done;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] vec [LENX];
    logic [WIDTH-1:0] exp_q [$];
    int               xfer_cycles [$];
    int               cyc = 0;
    int               send_idx = 0;
    int               done_cnt = 0;
    bit               exp_done = 1'b0;
    bit               mon_en = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    layer_x_stream_tx #(.WIDTH(WIDTH), .LENX(LENX), .ADDRX(ADDRX)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in    (s_data_in),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .replay       (replay),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks stall stability and done.
    always @(negedge clk) begin
        if (mon_en) begin
            check("done", {31'd0, done}, {31'd0, exp_done});
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (prev_stall) begin
                check("stall_valid", {31'd0, m_valid_x}, 32'd1);
                check("stall_data", {16'd0, m_data_out_x}, {16'd0, prev_data});
            end
            if (m_valid_x) check("ready_in_send", {31'd0, s_ready}, 32'd0);
            if (m_valid_x && m_ready_x) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", exp_q.size(), 32'd1);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    check("data", {16'd0, m_data_out_x}, {16'd0, e});
                    $display("[TB] sent word %0d = %0h (expected %0h)", send_idx, m_data_out_x, e);
                end
                xfer_cycles.push_back(cyc);
                if (send_idx == LENX - 1) begin
                    exp_done = 1'b1;
                    send_idx = 0;
                end else begin
                    send_idx++;
                end
            end
            prev_stall = m_valid_x && !m_ready_x;
            prev_data  = m_data_out_x;
        end
    end

    // Loads vec[0..n-1]; pushes each word to the scoreboard when it is accepted.
    task automatic load_vec(input int n, input bit gaps);
        int i = 0;
        int g = 0;
        while (i < n && g < 2000) begin
            g++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid   = 1'b0;
                s_data_in = WIDTH'($urandom);
            end else begin
                s_valid   = 1'b1;
                s_data_in = vec[i];
            end
            @(negedge clk);
            if (s_valid && s_ready) begin
                exp_q.push_back(vec[i]);
                $display("[TB] loaded word %0d = %0h", i, vec[i]);
                i++;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("load_count", i, n);
    endtask

    // Runs until the scoreboard drains; mode 0 holds ready, 1 toggles it, 2 holds it and
    // drives junk on the load port.
    task automatic wait_drain(input int mode);
        int g = 0;
        while ((exp_q.size() != 0 || send_idx != 0) && g < 500) begin
            if (mode == 1) m_ready_x = ~m_ready_x;
            if (mode == 2) begin
                s_valid   = 1'($urandom_range(0, 1));
                s_data_in = WIDTH'($urandom);
            end
            @(posedge clk);
            #1;
            g++;
        end
        s_valid = 1'b0;
        check("drain_timeout", {31'd0, g < 500}, 32'd1);
    endtask

    task automatic apply_reset(input int cycles);
        reset      = 1'b0;
        mon_en     = 1'b0;
        s_valid    = 1'b0;
        exp_q.delete();
        send_idx   = 0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
        #1;
        check("rst_valid", {31'd0, m_valid_x}, 32'd0);
        check("rst_data", {16'd0, m_data_out_x}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, s_ready}, 32'd0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("rst_hold_valid", {31'd0, m_valid_x}, 32'd0);
            check("rst_hold_ready", {31'd0, s_ready}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("ready_before_edge", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, s_ready}, 32'd1);
        mon_en = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        #2;
        apply_reset(3);

        // Incrementing vector, ready held high: 24 consecutive transfers and one done
        for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(i);
        m_ready_x = 1'b1;
        done_cnt  = 0;
        xfer_cycles.delete();
        load_vec(LENX, 1'b0);
        wait_drain(0);
        repeat (2) begin @(posedge clk); #1; end
        check("a_xfer_count", xfer_cycles.size(), LENX);
        if (xfer_cycles.size() == LENX)
            check("a_back_to_back", xfer_cycles[LENX-1] - xfer_cycles[0], LENX - 1);
        check("a_done_count", done_cnt, 1);
        check("a_back_to_load", {31'd0, s_ready}, 32'd1);

        // Extreme values with ready toggling every cycle
        vec[0] = 16'hFFFB;
        vec[1] = 16'd100;
        vec[2] = 16'h8000;
        vec[3] = 16'h7FFF;
        for (int i = 4; i < LENX; i++) vec[i] = WIDTH'($urandom);
        done_cnt = 0;
        load_vec(LENX, 1'b0);
        wait_drain(1);
        m_ready_x = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("b_done_count", done_cnt, 1);

        // Random load gaps; junk on the load port while sending
        for (int i = 0; i < LENX; i++) vec[i] = WIDTH'($urandom);
        done_cnt = 0;
        load_vec(LENX, 1'b1);
        wait_drain(2);
        repeat (2) begin @(posedge clk); #1; end
        check("c_done_count", done_cnt, 1);

        // Replay pulse on the done/WAIT cycle
        for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(16'h1000 + i * 7);
        done_cnt = 0;
        load_vec(LENX, 1'b0);
        wait_drain(0);
        replay = 1'b1;
`ifdef LAYER_X_STREAM_TX_REPLAY_EN
        for (int i = 0; i < LENX; i++) exp_q.push_back(vec[i]);
        @(posedge clk);
        #1;
        replay = 1'b0;
        check("replay_ready_low", {31'd0, s_ready}, 32'd0);
        wait_drain(0);
        repeat (2) begin @(posedge clk); #1; end
        check("replay_done_count", done_cnt, 2);
`else
        @(posedge clk);
        #1;
        replay = 1'b0;
        check("replay_ignored_ready", {31'd0, s_ready}, 32'd1);
        repeat (3) begin
            check("replay_ignored_valid", {31'd0, m_valid_x}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("replay_done_count", done_cnt, 1);
`endif

        // Reset after 10 load words; only the next full vector may be sent
        for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(16'hA000 + i);
        load_vec(10, 1'b0);
        apply_reset(2);
        for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(16'h5000 + i * 3);
        done_cnt = 0;
        load_vec(LENX, 1'b0);
        wait_drain(0);
        repeat (2) begin @(posedge clk); #1; end
        check("d_done_count", done_cnt, 1);

        // Reset while word 7 is presented
        for (int i = 0; i < LENX; i++) vec[i] = WIDTH'($urandom);
        load_vec(LENX, 1'b0);
        begin
            int g = 0;
            while (send_idx != 7 && g < 100) begin
                @(posedge clk);
                #1;
                g++;
            end
            check("e_reach_word7", send_idx, 7);
            check("e_word7_valid", {31'd0, m_valid_x}, 32'd1);
            check("e_word7_data", {16'd0, m_data_out_x}, {16'd0, vec[7]});
        end
        apply_reset(1);

        // Recovery: a fresh vector goes through normally
        for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(LENX - i);
        done_cnt = 0;
        load_vec(LENX, 1'b0);
        wait_drain(0);
        repeat (2) begin @(posedge clk); #1; end
        check("f_done_count", done_cnt, 1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_x_stream_tx.md
LAYER_X_STREAM_TX -- requirements
Module: layer_x_stream_tx

Interface
- REQ-001: Parameter WIDTH, default 16, data word width in bits.
- REQ-002: Parameter LENX, default 24, number of words per vector.
- REQ-003: Parameter ADDRX, default 5, buffer address width; it SHALL satisfy 2^ADDRX >= LENX.
- REQ-004: Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
- REQ-005: Port reset, input, 1, asynchronous active-low reset.
- REQ-006: Port s_data_in, input, WIDTH, signed load word.
- REQ-007: Port s_valid, input, 1, load word valid.
- REQ-008: Port s_ready, output, 1, block accepts a load word.
- REQ-009: Port m_data_out_x, output, WIDTH, signed word sent toward the layer x input.
- REQ-010: Port m_valid_x, output, 1, m_data_out_x is valid.
- REQ-011: Port m_ready_x, input, 1, downstream layer accepts a word.
- REQ-012: Port replay, input, 1, single-cycle request to resend the stored vector (active only with the macro in REQ-031).
- REQ-013: Port done, output, 1, one-cycle pulse after the last word of a vector transfers.

Function
- REQ-014: The block SHALL implement states IDLE, LOAD, SEND and WAIT.
- REQ-015: Reset SHALL enter LOAD.
- REQ-016: IDLE SHALL move to LOAD on the next cycle.
- REQ-017: A load transfer SHALL occur on a cycle with s_valid && s_ready; it SHALL write s_data_in to buffer[wcnt] and increment wcnt.
- REQ-018: s_ready SHALL be 1 exactly while in LOAD; s_ready SHALL be a registered decode of the state.
- REQ-019: On the transfer that writes index LENX-1, the state SHALL go to SEND, wcnt SHALL clear to 0, rcnt SHALL clear to 0, and s_ready SHALL drop the next cycle.
- REQ-020: In SEND, m_valid_x SHALL be 1 and m_data_out_x SHALL equal buffer[rcnt]; the first m_valid_x SHALL appear no later than 2 cycles after the final load transfer.
- REQ-021: An output transfer SHALL occur on a cycle with m_valid_x && m_ready_x; it SHALL advance rcnt by 1.
- REQ-022: While m_valid_x=1 and m_ready_x=0, m_data_out_x and m_valid_x SHALL remain stable; m_valid_x SHALL never drop without a transfer.
- REQ-023: Back-to-back transfers SHALL be supported: with m_ready_x held at 1, the block SHALL send one word per cycle with no bubbles, so LENX words go out in LENX consecutive cycles.
- REQ-024: On the transfer of index LENX-1, done SHALL pulse high for exactly the next cycle, m_valid_x SHALL drop the next cycle, and the state SHALL go to WAIT.
- REQ-025: WAIT SHALL go to LOAD in the next cycle, unless the replay path of REQ-031 applies.
- REQ-026: Words SHALL be sent in the order they were loaded, and the sent values SHALL be bit-exact copies of the loaded values.
- REQ-027: s_valid asserted outside LOAD SHALL be ignored; no buffer write SHALL occur.
- REQ-028: Counters SHALL never exceed LENX-1; no address at or beyond LENX SHALL ever be read or written.

Reset
- REQ-029: Asserting reset at any time, including mid-LOAD or mid-SEND, SHALL immediately force the following values, and the partial vector SHALL be discarded:
  - m_valid_x=0, m_data_out_x=0, done=0, s_ready=0;
  - wcnt=0, rcnt=0;
  - state LOAD, with s_ready rising on the first clock edge after reset deasserts.
- REQ-030: Buffer contents SHALL NOT be required to reset.

Configuration
- REQ-031: With macro LAYER_X_STREAM_TX_REPLAY_EN defined, replay=1 in WAIT, or on the done cycle, SHALL send the state to SEND with rcnt=0 and resend the stored vector without reloading.
- REQ-032: With LAYER_X_STREAM_TX_REPLAY_EN undefined, replay SHALL be ignored and WAIT SHALL always go to LOAD.

Verification
- REQ-033: Load 0,1,...,23 with s_valid=1 continuously, then hold m_ready_x=1 -> the block sends 0..23 in 24 consecutive cycles, and done pulses once one cycle after the word 23 transfer.
- REQ-034: Load -5,100,-32768,32767,...; toggle m_ready_x 1/0 every cycle -> each word stays stable while stalled, no word is lost or duplicated, and the output sequence matches the input bit-exactly.
- REQ-035: Drive s_valid randomly during load -> exactly 24 writes occur and s_ready=0 throughout SEND; an s_valid pulse during SEND does not alter the data.
- REQ-036: Assert reset after 10 load words, then load 24 new words -> all outputs are 0 during reset, and only the 24 new words are sent.
- REQ-037: Assert reset while sending word 7 -> m_valid_x=0 immediately, then s_ready=1 one clock after release.
- REQ-038: With LAYER_X_STREAM_TX_REPLAY_EN defined, pulse replay in WAIT -> the same 24 words are resent and a second done pulse follows.
- REQ-039: With LAYER_X_STREAM_TX_REPLAY_EN undefined, pulse replay in WAIT -> the block returns to LOAD with s_ready=1.
